// File: rtl/dpram_fifo_pkg.sv
// Shared constants for the two-channel DPRAM FIFO controller.
// Address layout is {channel, buffer index}.
package dpram_fifo_pkg;

  localparam int NCH   = 2;
  localparam int IDX_W = 7;
  localparam int DEPTH = 128;
  localparam int LVL_W = 8;

  function automatic logic [IDX_W:0] addr_of(
    input logic             chan,
    input logic [IDX_W-1:0] idx
  );
    return {chan, idx};
  endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter.
// The priority pointer flips to the loser after every grant.
module rr_arb2 (
  input  logic       ck,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_v
);

  logic ptr;

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      default: gnt = '0;
    endcase
    gnt_v = |req;
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (gnt_v) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Write scheduler and circular-buffer manager in front of a
// 256x16 dual-port RAM, one 128-word buffer per producer.
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  output logic [1:0]    ack,
  input  logic          rd_req,
  input  logic          rd_chan,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_vchan,
  output logic [AW-1:0] level0,
  output logic [AW-1:0] level1,
  output logic [1:0]    empty,
  output logic [1:0]    full,
  output logic [1:0]    overflow,
  input  logic [1:0]    clr_ovf,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          re,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata
);

  logic [IDX_W-1:0] wptr [NCH];
  logic [IDX_W-1:0] rptr [NCH];
  logic [LVL_W-1:0] lvl  [NCH];

  logic [1:0] elig;
  logic [1:0] gnt;
  logic       gnt_v;
  logic       gch;
  logic [1:0] wr_acc;
  logic [1:0] rd_acc;
  logic [1:0] drop;

  // a channel acked last cycle is still holding the consumed sample
  assign elig = req & ~ack;

  rr_arb2 u_arb (
    .ck    (ck),
    .rst_n (rst_n),
    .req   (elig),
    .gnt   (gnt),
    .gnt_v (gnt_v)
  );

  assign gch     = gnt[1];
  assign level0  = lvl[0];
  assign level1  = lvl[1];
  assign rd_data = rdata;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      empty[c] = (lvl[c] == '0);
      full[c]  = (lvl[c] == LVL_W'(DEPTH));
    end
    wr_acc = gnt & ~full;
    drop   = gnt & full;
    rd_acc = '0;
    if (rd_req) begin
      rd_acc[rd_chan] = !empty[rd_chan];
    end
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      ack      <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      re       <= 1'b0;
      raddr    <= '0;
      rd_valid <= 1'b0;
      rd_vchan <= 1'b0;
      overflow <= '0;
      for (int c = 0; c < NCH; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        lvl[c]  <= '0;
      end
    end else begin
      ack <= gnt;
      we  <= gnt_v && !full[gch];
      if (|wr_acc) begin
        waddr <= addr_of(gch, wptr[gch]);
        wdata <= gch ? data1 : data0;
      end
      re <= |rd_acc;
      if (|rd_acc) begin
        raddr <= addr_of(rd_chan, rptr[rd_chan]);
      end
      rd_valid <= re;
      if (re) begin
        rd_vchan <= raddr[AW-1];
      end
      overflow <= drop | (overflow & ~clr_ovf);
      for (int c = 0; c < NCH; c++) begin
        if (wr_acc[c]) begin
          wptr[c] <= wptr[c] + IDX_W'(1);
        end
        if (rd_acc[c]) begin
          rptr[c] <= rptr[c] + IDX_W'(1);
        end
        unique case ({wr_acc[c], rd_acc[c]})
          2'b10:   lvl[c] <= lvl[c] + LVL_W'(1);
          2'b01:   lvl[c] <= lvl[c] - LVL_W'(1);
          default: lvl[c] <= lvl[c];
        endcase
      end
    end
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Scheduler and buffer manager sitting in front of the 256x16 `DPRAM` block. It shares the single RAM write port between two sample producers using round-robin arbitration. Each producer gets its own 128-word circular buffer (RAM half 0 and half 1). A consumer drains either buffer through the RAM read port with a fixed-latency request/valid protocol. The RAM is external to this block: it drives the RAM's write and read ports, and both RAM clocks are tied to `ck`.

## Interface
Parameters:
- `DW`, 16: sample and RAM data width.
- `AW`, 8: RAM address width; the MSB selects the channel, the low `AW-1` bits are the buffer index.

Ports:
- `ck` in 1: single clock; the RAM's `wclk`/`rclk` are also driven from it.
- `rst_n` in 1: reset, synchronous, active-low.
- `req` in 2: per-channel write request, level; held with data until `ack`.
- `data0`, `data1` in DW: sample for channel 0 / channel 1.
- `ack` out 2: one-cycle pulse; the sample on that channel is consumed (written or dropped).
- `rd_req` in 1: consumer read request, one word per asserted cycle.
- `rd_chan` in 1: channel to read.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `rd_data` out DW: sample read from the RAM.
- `rd_vchan` out 1: channel of `rd_data`.
- `level0`, `level1` out AW: fill count, range 0..128.
- `empty`, `full` out 2: per-channel status, derived combinationally from the level.
- `overflow` out 2: sticky per-channel drop flag.
- `clr_ovf` in 2: clears the matching `overflow` bit.
- `we`, `waddr` (AW), `wdata` (DW): RAM write port outputs, registered.
- `re`, `raddr` (AW): RAM read port outputs, registered.
- `rdata` in DW: RAM read data; registered inside the RAM, one cycle after `re`.

## Operation
- Reset values:
  - outputs: `ack`=0, `we`=0, `re`=0, `rd_valid`=0, `waddr`=0, `raddr`=0, `wdata`=0, `rd_vchan`=0, `overflow`=0, `level*`=0 (so `empty`=2'b11, `full`=0).
  - internal: write/read pointers = 0, round-robin pointer = channel 0.
- Write arbitration, once per cycle:
  - A grant goes to one requesting channel whose `ack` was not asserted in the previous cycle, so a held `req` is not double-counted.
  - If both channels are eligible, the round-robin pointer wins. After any grant the pointer moves to the other channel.
- A granted write to channel c has two outcomes:
  - Not full: `we`=1, `waddr`={c, wptr_c}, `wdata`=data_c, `ack[c]`=1, and wptr_c increments modulo 128 (127 wraps to 0).
  - Full: `we`=0, `ack[c]`=1, the sample is dropped, `overflow[c]` is set, and the pointer is unchanged.
- Full is judged on the level at the start of the cycle. A read of the same channel in the same cycle does not rescue the write.
- Read:
  - `rd_req` with `rd_chan`=c, c not empty: `re`=1, `raddr`={c, rptr_c}, rptr_c increments modulo 128.
  - `rd_req` to an empty channel is ignored: no `re`, no `rd_valid`, no error.
- Level per channel: +1 on an accepted write, -1 on an accepted read, unchanged when both happen in the same cycle.
- `overflow[c]`: set wins over `clr_ovf[c]` in the same cycle.
- Reset mid-operation: all state returns to the reset values at the next edge. An in-flight read is lost (no `rd_valid`).

## Timing
- Write: `req` sampled at edge E0. `ack`, `we`, `waddr` and `wdata` are high/valid during the cycle after E0, and the RAM captures at E1.
- Fastest back-to-back writes for one channel: one every 2 cycles, because `ack` blanks the next cycle.
- Both channels requesting: writes alternate, one per cycle.
- Read: `rd_req` sampled at E0, so `re`/`raddr` are valid after E0. The RAM registers `rdata` at E1. `rd_valid`, `rd_data`=`rdata` and `rd_vchan` are valid in the cycle after E1. Latency is 2 cycles; throughput is 1 per cycle.
- `level`, `empty`, `full` update at the edge on which the write or read is accepted, i.e. E0.

## Structure
- Package `dpram_fifo_pkg`, shared constants:
  - `NCH`=2
  - `IDX_W`=7
  - `DEPTH`=128
  - `LVL_W`=8
  - address-compose function {chan, idx}.
- Sub-module `rr_arb2`: 2-requester round-robin arbiter with a registered priority pointer. Inputs are the eligible requests; outputs are the grant one-hot and grant-valid.
- Top level: pointer, level and overflow registers; write/read port registers; 1-deep read-valid pipeline.

## Test plan
- Reset, then `req`=01 with `data0`=16'hA5A5 → `ack`=01, `we`=1, `waddr`=8'h00, `wdata`=16'hA5A5; `level0`=1; `empty`=10.
- `req`=11 held for 6 cycles → grants alternate ch0, ch1, ch0…; `waddr` sequence 00, 80, 01, 81, 02, 82.
- Write 128 samples to ch1 → `full[1]`=1, `level1`=128. The 129th write → `ack[1]` pulse, `we`=0, `overflow[1]`=1. Then `clr_ovf[1]` → `overflow[1]`=0.
- Write 0x0001..0x0003 to ch0, then `rd_req` with `rd_chan`=0 for 3 cycles → `rd_valid` for 3 cycles starting 2 cycles later, data 1, 2, 3, `rd_vchan`=0. A 4th `rd_req` → nothing.
- Wrap: 130 write/read pairs on ch0 → `waddr` goes 7F then 00; `level0` never exceeds 1; data intact.
- `rst_n`=0 for one cycle while a read is in flight → no `rd_valid`, all levels 0, next write lands at `waddr` 00.
